load_store_unit: RTL and testbench

- Sits between the core's memory stage and the word-addressed data memory (asynchronous read, synchronous whole-word write).
- Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Implements sub-word stores as a read-modify-write and sign- or zero-extends loads.
- Flags misaligned, out-of-range and illegal requests without touching memory.

---
 rtl/load_store_unit_if.sv | 43 ++++
 rtl/load_store_unit.sv | 211 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core/memory-side bundle for the load/store unit.
// The master side is the core plus data memory; the slave side is the LSU itself.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  // request from the core
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  // response to the core
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error;

  // word-addressed data memory port
  logic [IDX_W-1:0]      mem_addr;
  logic [31:0]           mem_write_data;
  logic                  mem_write;
  logic [31:0]           mem_dout;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    input  mem_addr, mem_write_data, mem_write,
    output mem_dout
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    output mem_addr, mem_write_data, mem_write,
    input  mem_dout
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests
// into whole-word accesses on a word-addressed memory. Sub-word stores are
// done as read-modify-write; loads are sign- or zero-extended. Illegal,
// misaligned and out-of-range requests are answered with an error and never
// touch memory.
module load_store_unit #(
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  load_store_unit_if.slave bus
);

  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam int RANGE_LSB = IDX_W + 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    LOAD,
    MERGE,
    WRITE,
    RESP
  } state_t;

  state_t state, next_state;

  // request context captured at accept
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       off_q;
  logic [2:0]       funct3_q;
  logic [15:0]      wdata_q;
  logic             err_q;

  // registered outputs
  logic [31:0]      rdata_q;
  logic [31:0]      wr_data_q;

  // request decode
  logic                  accept;
  logic [IDX_W-1:0]      req_idx;
  logic [1:0]            req_off;
  logic [ADDR_WIDTH-1:0] addr_hi;
  logic                  out_of_range;
  logic                  funct3_ok;
  logic                  misaligned;
  logic                  req_err;

  // datapath
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_value;
  logic [31:0] merged_word;

  assign accept       = (state == IDLE) && bus.req_valid;
  assign req_idx      = bus.req_addr[IDX_W+1:2];
  assign req_off      = bus.req_addr[1:0];
  assign addr_hi      = bus.req_addr >> RANGE_LSB;
  assign out_of_range = (addr_hi != '0);

  // Classify the incoming request: legal access type for its direction and natural alignment.
  always_comb begin
    funct3_ok  = 1'b0;
    misaligned = 1'b0;
    case (bus.req_funct3)
      F3_B: begin
        funct3_ok = 1'b1;
      end
      F3_H: begin
        funct3_ok  = 1'b1;
        misaligned = req_off[0];
      end
      F3_W: begin
        funct3_ok  = 1'b1;
        misaligned = (req_off != 2'b00);
      end
      F3_BU: begin
        funct3_ok = !bus.req_we;
      end
      F3_HU: begin
        funct3_ok  = !bus.req_we;
        misaligned = req_off[0];
      end
      default: begin
        funct3_ok = 1'b0;
      end
    endcase
    req_err = !funct3_ok || misaligned || out_of_range;
  end

  // Pick the addressed byte/halfword out of the memory word and extend it for the core.
  always_comb begin
    sel_byte   = 8'h00;
    sel_half   = 16'h0000;
    load_value = bus.mem_dout;
    case (off_q)
      2'd0:    sel_byte = bus.mem_dout[7:0];
      2'd1:    sel_byte = bus.mem_dout[15:8];
      2'd2:    sel_byte = bus.mem_dout[23:16];
      default: sel_byte = bus.mem_dout[31:24];
    endcase
    sel_half = off_q[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];
    case (funct3_q)
      F3_B:    load_value = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_value = {24'h000000, sel_byte};
      F3_H:    load_value = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_value = {16'h0000, sel_half};
      default: load_value = bus.mem_dout;
    endcase
  end

  // Overlay the store byte/halfword onto the current memory word, leaving other lanes intact.
  always_comb begin
    merged_word = bus.mem_dout;
    if (funct3_q == F3_H) begin
      if (off_q[1]) begin
        merged_word[31:16] = wdata_q;
      end else begin
        merged_word[15:0] = wdata_q;
      end
    end else begin
      case (off_q)
        2'd0:    merged_word[7:0]   = wdata_q[7:0];
        2'd1:    merged_word[15:8]  = wdata_q[7:0];
        2'd2:    merged_word[23:16] = wdata_q[7:0];
        default: merged_word[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // State register; async reset drops straight back to IDLE, aborting any request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Sequencing: errors and loads take one working cycle, SW writes directly, SB/SH read first.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err) begin
            next_state = ERR;
          end else if (!bus.req_we) begin
            next_state = LOAD;
          end else if (bus.req_funct3 == F3_W) begin
            next_state = WRITE;
          end else begin
            next_state = MERGE;
          end
        end
      end
      ERR:     next_state = RESP;
      LOAD:    next_state = RESP;
      MERGE:   next_state = WRITE;
      WRITE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture the request on accept and register load results and merged store words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      off_q     <= 2'b00;
      funct3_q  <= 3'b000;
      wdata_q   <= 16'h0000;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      wr_data_q <= 32'h0000_0000;
    end else begin
      if (accept) begin
        idx_q    <= req_idx;
        off_q    <= req_off;
        funct3_q <= bus.req_funct3;
        wdata_q  <= bus.req_wdata[15:0];
        err_q    <= req_err;
        rdata_q  <= 32'h0000_0000;
        if (!req_err && bus.req_we && (bus.req_funct3 == F3_W)) begin
          wr_data_q <= bus.req_wdata;
        end
      end else if (state == LOAD) begin
        rdata_q <= load_value;
      end else if (state == MERGE) begin
        wr_data_q <= merged_word;
      end
    end
  end

  // Handshake and memory strobes come straight from the state so reset kills them at once.
  assign bus.req_ready      = (state == IDLE);
  assign bus.rsp_valid      = (state == RESP);
  assign bus.rsp_error      = (state == RESP) && err_q;
  assign bus.rsp_rdata      = rdata_q;
  assign bus.mem_addr       = idx_q;
  assign bus.mem_write_data = wr_data_q;
  assign bus.mem_write      = (state == WRITE);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized requests checked
// against a byte-level reference model of memory and the access rules.
module tb_load_store_unit;

  localparam int MEM_DEPTH  = 1024;
  localparam int ADDR_WIDTH = 32;
  localparam int USED_WORDS = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH)) bus ();

  load_store_unit #(.MEM_DEPTH(MEM_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // data memory seen by the DUT, with a backdoor write port for preloading
  logic [31:0] mem     [MEM_DEPTH];
  logic [31:0] ref_mem [MEM_DEPTH];
  logic        bd_we   = 1'b0;
  logic [9:0]  bd_idx  = '0;
  logic [31:0] bd_data = '0;

  assign bus.mem_dout = mem[bus.mem_addr];

  // synchronous whole-word write; the DUT port has priority over the backdoor
  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_write_data;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic preloadWord(input int idx, input logic [31:0] data);
    bd_idx  = idx[9:0];
    bd_data = data;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
    ref_mem[idx] = data;
  endtask

  // ---------------- reference model ----------------
  function automatic int refSize(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit refIsError(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    if (!legal) return 1'b1;
    if (addr % refSize(f3) != 0) return 1'b1;
    if (addr >= 32'(MEM_DEPTH * 4)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int sz;
    sz = refSize(f3);
    v  = word >> (8 * (addr % 4));
    if (sz == 1) v = v % 256;
    if (sz == 2) v = v % 65536;
    if (f3 == 3'd0 && v >= 128)   v = v + 32'hFFFF_FF00;
    if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [31:0] refStore(input logic [31:0] old, input logic [2:0] f3,
                                           input logic [31:0] addr, input logic [31:0] wdata);
    logic [7:0]  b [4];
    logic [31:0] res;
    int off;
    off = int'(addr % 4);
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    for (int k = 0; k < refSize(f3); k++) b[off + k] = wdata[8*k +: 8];
    res = '0;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = b[i];
    return res;
  endfunction

  // ---------------- stimulus ----------------
  // Called just after a negedge; returns at the negedge where rsp_valid is seen.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit hold,
                               output logic [31:0] rdata, output logic err, output int latency,
                               output int writes, output int ready_waits);
    bit done;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    ready_waits = 0;
    while (!bus.req_ready && ready_waits < 20) begin
      @(negedge clk);
      ready_waits++;
    end
    if (ready_waits >= 20) checkOutput("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    latency = 0;
    writes  = 0;
    done    = 1'b0;
    rdata   = '0;
    err     = 1'b0;
    while (!done && latency < 10) begin
      @(negedge clk);
      latency++;
      if (latency == 1 && !hold) bus.req_valid = 1'b0;
      if (bus.mem_write) writes++;
      if (bus.rsp_valid) begin
        done  = 1'b1;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_error;
      end
    end
    checkOutput("rsp_valid_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic doOp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit hold,
                      output logic [31:0] rdata, output int ready_waits);
    logic        exp_err, err;
    logic [31:0] exp_rdata;
    int          exp_lat, exp_wr, lat, wr, idx;
    idx       = int'((addr / 4) % MEM_DEPTH);
    exp_err   = refIsError(we, f3, addr);
    exp_rdata = (exp_err || we) ? 32'h0 : refLoad(ref_mem[idx], f3, addr);
    exp_lat   = (!exp_err && we && refSize(f3) < 4) ? 3 : 2;
    exp_wr    = (!exp_err && we) ? 1 : 0;
    applyStimulus(we, f3, addr, wdata, hold, rdata, err, lat, wr, ready_waits);
    if (!exp_err && we) ref_mem[idx] = refStore(ref_mem[idx], f3, addr, wdata);
    checkOutput("rsp_error", {31'b0, err}, {31'b0, exp_err});
    checkOutput("rsp_rdata", rdata, exp_rdata);
    checkOutput("latency", lat, exp_lat);
    checkOutput("write_pulses", wr, exp_wr);
    checkOutput("mem_word", mem[idx], ref_mem[idx]);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] rd, orig, addr, wdata;
    logic [2:0]  f3;
    logic        we;
    int          waits, wr_cnt, rv_cnt, mism;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    #2 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < USED_WORDS; i++) preloadWord(i, $urandom);

    checkOutput("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("reset_rsp_error", {31'b0, bus.rsp_error}, 32'd0);
    checkOutput("reset_mem_write", {31'b0, bus.mem_write}, 32'd0);
    checkOutput("reset_mem_addr", {22'b0, bus.mem_addr}, 32'd0);
    checkOutput("reset_mem_wdata", bus.mem_write_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'b0, bus.req_ready}, 32'd1);

    // loads from a known word
    preloadWord(5, 32'h8899_AABB);
    doOp(1'b0, 3'b000, 32'h15, 32'h0, 1'b0, rd, waits);
    checkOutput("lb_0x15", rd, 32'hFFFF_FFAA);
    doOp(1'b0, 3'b100, 32'h15, 32'h0, 1'b0, rd, waits);
    checkOutput("lbu_0x15", rd, 32'h0000_00AA);
    doOp(1'b0, 3'b001, 32'h16, 32'h0, 1'b0, rd, waits);
    checkOutput("lh_0x16", rd, 32'hFFFF_8899);
    doOp(1'b0, 3'b101, 32'h14, 32'h0, 1'b0, rd, waits);
    checkOutput("lhu_0x14", rd, 32'h0000_AABB);
    doOp(1'b0, 3'b010, 32'h14, 32'h0, 1'b0, rd, waits);
    checkOutput("lw_0x14", rd, 32'h8899_AABB);
    checkOutput("mem_addr_hold", {22'b0, bus.mem_addr}, 32'd5);

    // sub-word stores
    preloadWord(3, 32'h1122_3344);
    doOp(1'b1, 3'b000, 32'h0E, 32'hFFFF_FF5A, 1'b0, rd, waits);
    checkOutput("sb_word3", mem[3], 32'h115A_3344);
    doOp(1'b1, 3'b001, 32'h0C, 32'h0000_BEEF, 1'b0, rd, waits);
    checkOutput("sh_word3", mem[3], 32'h115A_BEEF);

    // rejected requests
    doOp(1'b0, 3'b010, 32'h02, 32'h0, 1'b0, rd, waits);
    doOp(1'b1, 3'b001, 32'h01, 32'h1234_5678, 1'b0, rd, waits);
    doOp(1'b1, 3'b100, 32'h10, 32'h1234_5678, 1'b0, rd, waits);
    doOp(1'b0, 3'b010, 32'h1000, 32'h0, 1'b0, rd, waits);

    // reset during the MERGE cycle aborts the store
    @(negedge clk);
    orig = ref_mem[2];
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h08;
    bus.req_wdata  = 32'h0000_0077;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    wr_cnt = 0;
    rv_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.mem_write) wr_cnt++;
      if (bus.rsp_valid) rv_cnt++;
      @(negedge clk);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.mem_write) wr_cnt++;
      if (bus.rsp_valid) rv_cnt++;
    end
    checkOutput("abort_writes", wr_cnt, 0);
    checkOutput("abort_rsp", rv_cnt, 0);
    checkOutput("abort_ready", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("abort_word2", mem[2], orig);
    doOp(1'b0, 3'b010, 32'h08, 32'h0, 1'b0, rd, waits);
    checkOutput("lw_after_abort", rd, orig);

    // back-to-back with req_valid held high
    doOp(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, 1'b1, rd, waits);
    doOp(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, rd, waits);
    checkOutput("b2b_ready_waits", waits, 1);
    checkOutput("b2b_lw", rd, 32'hCAFE_F00D);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      we    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = 32'($urandom_range(0, USED_WORDS * 4 - 1));
      if ($urandom_range(0, 9) == 0) addr = addr | (32'h1 << $urandom_range(12, 31));
      wdata = $urandom;
      doOp(we, f3, addr, wdata, 1'b0, rd, waits);
    end

    mism = 0;
    for (int i = 0; i < USED_WORDS; i++) begin
      if (mem[i] !== ref_mem[i]) mism++;
    end
    checkOutput("mem_scan", mism, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
